// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-issue stage and the ALU itself.
package alu_pkg;

   localparam int DATA_W   = 16;
   localparam int OPC_W    = 4;
   localparam int REG_AW   = 3;
   localparam int NUM_REGS = 1 << REG_AW;

   // Opcode encodings shared with the ALU; the issue stage passes them through untouched.
   localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
   localparam logic [OPC_W-1:0] OP_SUB  = 4'h1;
   localparam logic [OPC_W-1:0] OP_AND  = 4'h2;
   localparam logic [OPC_W-1:0] OP_OR   = 4'h3;
   localparam logic [OPC_W-1:0] OP_XOR  = 4'h4;
   localparam logic [OPC_W-1:0] OP_SHL  = 4'h5;
   localparam logic [OPC_W-1:0] OP_SHR  = 4'h6;
   localparam logic [OPC_W-1:0] OP_PASS = 4'h7;

   // One register-addressed ALU instruction as held in the issue FIFO.
   typedef struct packed {
      logic [OPC_W-1:0]  opcode;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } instr_t;

   // r0 is hardwired to zero: never written, never tracked as pending.
   function automatic logic is_zero_reg(input logic [REG_AW-1:0] idx);
      return idx == '0;
   endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// In-order synchronous FIFO of instructions with occupancy outputs.
module alu_issue_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  instr_t                   push_data,
   input  logic                     pop,
   output instr_t                   head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   instr_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Pointers wrap naturally; count moves only when push and pop differ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is data only; validity is carried entirely by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage: buffers instructions, reads the register file, drives
// the ALU, writes results back after a fixed latency and stalls on hazards.
module alu_issue
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPC_W-1:0]    in_opcode,
   input  logic [REG_AW-1:0]   in_rd,
   input  logic [REG_AW-1:0]   in_rs1,
   input  logic [REG_AW-1:0]   in_rs2,
   output logic                alu_valid,
   output logic [DATA_W-1:0]   alu_A,
   output logic [DATA_W-1:0]   alu_B,
   output logic [OPC_W-1:0]    alu_opcode,
   input  logic [DATA_W-1:0]   alu_result,
   input  logic [REG_AW-1:0]   dbg_addr,
   output logic [DATA_W-1:0]   dbg_data
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   instr_t              in_instr;
   instr_t              head;
   logic                push;
   logic                issue;
   logic                hazard;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CW-1:0]       fifo_count;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pending_nxt;
   logic [DATA_W-1:0]   rs1_val;
   logic [DATA_W-1:0]   rs2_val;

   logic [REG_AW-1:0]   issue_rd;
   logic                trk_vld_p [ALU_LAT];
   logic [REG_AW-1:0]   trk_rd_p  [ALU_LAT];
   logic                wb_en;
   logic [REG_AW-1:0]   wb_rd;

   assign in_instr = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2};

   // A full FIFO refuses even when it pops in the same cycle.
   assign in_ready = (fifo_count < DEPTH_C);
   assign push     = in_valid && !fifo_full;

   alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (in_instr),
      .pop       (issue),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Head may issue only when none of its registers has a result in flight.
   assign hazard  = pending[head.rs1] || pending[head.rs2] || pending[head.rd];
   assign issue   = !fifo_empty && !hazard;
   assign rs1_val = is_zero_reg(head.rs1) ? '0 : regs[head.rs1];
   assign rs2_val = is_zero_reg(head.rs2) ? '0 : regs[head.rs2];

   assign wb_en = trk_vld_p[ALU_LAT-1];
   assign wb_rd = trk_rd_p[ALU_LAT-1];

   // Scoreboard update: writeback clears, issue sets, and set wins on a tie.
   always_comb begin
      pending_nxt = pending;
      if (wb_en) pending_nxt[wb_rd] = 1'b0;
      if (issue && !is_zero_reg(head.rd)) pending_nxt[head.rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_nxt;
   end

   // Issue stage: capture operands from pre-edge regfile; hold them when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_valid  <= 1'b0;
         alu_A      <= '0;
         alu_B      <= '0;
         alu_opcode <= '0;
         issue_rd   <= '0;
      end else begin
         alu_valid <= issue;
         if (issue) begin
            alu_A      <= rs1_val;
            alu_B      <= rs2_val;
            alu_opcode <= head.opcode;
            issue_rd   <= head.rd;
         end
      end
   end

   // Result tracker: last stage lines up with the alu_result-valid cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ALU_LAT; i++) begin
            trk_vld_p[i] <= 1'b0;
            trk_rd_p[i]  <= '0;
         end
      end else begin
         trk_vld_p[0] <= alu_valid;
         trk_rd_p[0]  <= issue_rd;
         for (int i = 1; i < ALU_LAT; i++) begin
            trk_vld_p[i] <= trk_vld_p[i-1];
            trk_rd_p[i]  <= trk_rd_p[i-1];
         end
      end
   end

   // Writeback into the register file; writes aimed at r0 are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_en && !is_zero_reg(wb_rd)) begin
         regs[wb_rd] <= alu_result;
      end
   end

   assign dbg_data = is_zero_reg(dbg_addr) ? '0 : regs[dbg_addr];

endmodule
